rr_grant_sequencer: RTL and testbench

- Sequences ownership of a shared 8-way resource among 8 requesters with a registered round-robin arbiter.
- Emits a one-hot grant vector and a 4-bit binary grant index whose encoding matches the team's 8-to-3 one-hot encoder output format, so downstream muxes can be driven directly.
- The grant is held until the owner finishes, drops its request, or exceeds a hold limit.
- The block sits between requesting engines and the shared datapath/bus mux.

---
 rtl/rr_grant_sequencer.sv | 139 +++++++++++++
 tb/tb_rr_grant_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sequencer.sv
// -----------------------------------------------------------------------------
// rr_grant_sequencer
//
// Hands ownership of a shared 8-way resource to one of 8 requesters at a time
// using a registered round-robin arbiter. A grant is held until the owner
// raises done, drops its request, or reaches the hold limit. Every grant is
// followed by a one-cycle bus turnaround before the next arbitration.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[7:0]     request vector, bit i = requester i
//   done         owner finished its transaction (only looked at while granted)
//   grant[7:0]   registered one-hot grant, zero when no owner
//   grant_idx    binary owner index in 8-to-3 encoder format (bit 3 always 0)
//   grant_valid  high while a grant is active
//   timeout      one-cycle pulse after a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module rr_grant_sequencer #(
  parameter int N        = 8,   // number of requesters; only 8 is supported
  parameter int MAX_HOLD = 16,  // max cycles per grant, 1..255
  parameter int CNT_W    = 8    // hold counter width, 2**CNT_W > MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic [3:0]   grant_idx,
  output logic         grant_valid,
  output logic         timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [2:0]       idx_q, idx_d;     // current owner, 0 when idle
  logic [2:0]       ptr_q, ptr_d;     // highest-priority requester next round
  logic [CNT_W-1:0] cnt_q, cnt_d;     // cycles the current owner has held
  logic             timeout_q, timeout_d;

  logic [2:0]       sel;              // arbitration winner
  logic [2:0]       cand;
  logic             hold_hit;
  logic             release_now;

  // Round-robin pick: walk from the farthest candidate back toward ptr so the
  // last match written is the first set bit at or after ptr (with wrap).
  always_comb begin
    sel  = ptr_q;
    cand = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req[cand]) begin
        sel = cand;
      end
    end
  end

  assign hold_hit    = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign release_now = done || !req[idx_q] || hold_hit;

  // Next-state and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = N'(1) << sel;
          idx_d   = sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (release_now) begin
          grant_d   = '0;
          idx_d     = '0;
          ptr_d     = idx_q + 3'd1;   // previous owner drops to lowest priority
          state_d   = TURN;
          // Flag the revocation only when the hold limit alone forced it.
          timeout_d = hold_hit && !done && req[idx_q];
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TURN: begin
        state_d = IDLE;               // one dead cycle for bus turnaround
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = {1'b0, idx_q};
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_sequencer
//
// Directed bench for rr_grant_sequencer (N=8, MAX_HOLD=16). Each task drives
// one scenario and compares outputs against hand-computed values; a negedge
// monitor also checks the output invariants every cycle.
// -----------------------------------------------------------------------------
module tb_rr_grant_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [3:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_grant_sequencer #(
    .N        (8),
    .MAX_HOLD (16),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge and new
  // inputs driven at that point take effect on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Invariants: grant zero or one-hot, grant_idx encodes grant, valid = |grant.
  always @(negedge clk) begin
    logic [3:0] exp_idx;
    exp_idx = 4'd0;
    for (int i = 0; i < 8; i++) if (grant[i]) exp_idx = 4'(i);
    checks++;
    if ($countones(grant) > 1 || grant_idx !== exp_idx || grant_valid !== (|grant)) begin
      errors++;
      $display("FAIL invariant t=%0t: grant=%b grant_idx=%0d grant_valid=%b, required one-hot grant, grant_idx=%0d, grant_valid=%b",
               $time, grant, grant_idx, grant_valid, exp_idx, |grant);
    end
  end

  task automatic test_reset();
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 8'h00 || grant_idx !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: grant=%h idx=%0d valid=%b timeout=%b, required all zero",
                 c, grant, grant_idx, grant_valid, timeout);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 8'h01 || grant_idx !== 4'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%h idx=%0d valid=%b, required grant=01 idx=0 valid=1",
               grant, grant_idx, grant_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      checks++;
      if (grant !== (8'h01 << exp_seq[g]) || grant_idx !== 4'(exp_seq[g])) begin
        errors++;
        $display("FAIL rr_grant %0d: grant=%h idx=%0d, required idx=%0d", g, grant, grant_idx, exp_seq[g]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 8'h00 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rr_release %0d: grant=%h timeout=%b, required grant=00 timeout=0", g, grant, timeout);
      end
      tick();
      checks++;
      if (grant !== 8'h00) begin
        errors++;
        $display("FAIL rr_gap %0d: grant=%h, required 00 in second idle cycle", g, grant);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 8'h20;
    tick();
    checks++;
    if (grant_idx !== 4'd5) begin
      errors++;
      $display("FAIL wrap_setup: grant_idx=%0d, required 5", grant_idx);
    end
    req = 8'b0000_0101;            // owner 5 drops, ptr becomes 6
    tick();
    tick();
    tick();
    checks++;
    if (grant_idx !== 4'd0 || grant !== 8'h01) begin
      errors++;
      $display("FAIL wrap_to_0: grant=%h idx=%0d, required grant=01 idx=0", grant, grant_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    checks++;
    if (grant_idx !== 4'd2 || grant !== 8'h04) begin
      errors++;
      $display("FAIL skip_to_2: grant=%h idx=%0d, required grant=04 idx=2", grant, grant_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    checks++;
    if (grant_idx !== 4'd0 || grant !== 8'h01) begin
      errors++;
      $display("FAIL wrap_back_0: grant=%h idx=%0d, required grant=01 idx=0", grant, grant_idx);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++;
      if (grant !== 8'h08 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold cycle %0d: grant=%h timeout=%b, required grant=08 timeout=0", c, grant, timeout);
      end
    end
    tick();
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_revoke: grant=%h timeout=%b, required grant=00 timeout=1", grant, timeout);
    end
    tick();
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: grant=%h timeout=%b, required grant=00 timeout=0", grant, timeout);
    end
    tick();
    checks++;
    if (grant !== 8'h08 || grant_idx !== 4'd3) begin
      errors++;
      $display("FAIL timeout_regrant: grant=%h idx=%0d, required grant=08 idx=3", grant, grant_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done_release: timeout=%b, required 0", timeout);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 8'h10;
    tick();                         // grant cycle 1
    checks++;
    if (grant !== 8'h10) begin
      errors++;
      $display("FAIL drop_grant: grant=%h, required 10", grant);
    end
    req = 8'b0101_0011;             // non-owner changes must not disturb owner 4
    tick();                         // cycle 2
    tick();                         // cycle 3
    checks++;
    if (grant !== 8'h10) begin
      errors++;
      $display("FAIL drop_hold: grant=%h, required 10", grant);
    end
    req = 8'b0100_0011;             // owner drops its request
    tick();
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: grant=%h timeout=%b, required grant=00 timeout=0", grant, timeout);
    end
    tick();
    tick();
    checks++;
    if (grant_idx !== 4'd6 || grant !== 8'h40) begin
      errors++;
      $display("FAIL drop_next: grant=%h idx=%0d, required grant=40 idx=6", grant, grant_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h04;
    tick();                         // hold cycle 1
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if (grant !== 8'h04) begin
        errors++;
        $display("FAIL midrst_hold cycle %0d: grant=%h, required 04", c, grant);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 8'h00 || grant_idx !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: grant=%h idx=%0d valid=%b timeout=%b, required all zero",
               grant, grant_idx, grant_valid, timeout);
    end
    rst = 1'b0;
    req = 8'h06;
    tick();
    checks++;
    if (grant_idx !== 4'd1 || grant !== 8'h02) begin
      errors++;
      $display("FAIL midrst_ptr: grant=%h idx=%0d, required grant=02 idx=1", grant, grant_idx);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_timeout();
    test_req_drop();
    test_reset_mid_grant();
    req = 8'h00;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
